rx_frame_buf: RTL and testbench
===============================

RX_FRAME_BUF -- requirements
Module: rx_frame_buf

Interface
REQ-001 SHALL have parameter BUF_AW, default 11: frame buffer address width (2048 bytes).
REQ-002 SHALL have parameter MIN_LEN, default 5: minimum legal frame length in bytes (DA, FC, MODE, CRC-hi, CRC-lo).
REQ-003 SHALL have port clk, input, 1 bit: single clock; every register in the block is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port byte_valid, input, 1 bit: byte_data is valid this cycle.
REQ-006 SHALL have port byte_data, input, 8 bits: received byte from the deserializer.
REQ-007 SHALL have port frame_sof, input, 1 bit: qualified by byte_valid; this byte is the first byte of a frame.
REQ-008 SHALL have port frame_eof, input, 1 bit: qualified by byte_valid; this byte is the last byte of a frame.
REQ-009 SHALL have port rx_buf_rden, input, 1 bit: read enable from the downstream consumer.
REQ-010 SHALL have port rx_buf_raddr, input, 11 bits: read address from the downstream consumer.
REQ-011 SHALL have port rx_buf_rdata, output, 8 bits: read data, valid 1 cycle after rx_buf_rden.
REQ-012 SHALL have port rx_start, output, 1 bit: 1-cycle pulse marking frame start.
REQ-013 SHALL have port rx_done, output, 1 bit: 1-cycle pulse marking that a frame is stored and checked.
REQ-014 SHALL have port rx_crc_rslt, output, 2 bits: 00 none, 01 CRC ok, 10 CRC error, 11 length error.
REQ-015 SHALL have port rx_len, output, 11 bits: stored byte count of the last frame, CRC bytes included.

Function
REQ-016 SHALL implement FSM states IDLE, RECV, CHECK, DONE.
REQ-017 IDLE: on byte_valid&frame_sof, SHALL write the byte at address 0, set wptr=1, seed CRC, pulse rx_start the next cycle, and go to RECV.
REQ-018 IDLE: SHALL ignore bytes that arrive without frame_sof.
REQ-019 RECV: on each byte_valid, SHALL write byte_data at wptr, then increment wptr and update the CRC.
REQ-020 SHALL use CRC-16 poly 0x1021, init 0xFFFF, MSB-first, no final XOR, computed over all bytes including the two trailing CRC bytes; a residue of 0x0000 means ok.
REQ-021 RECV: a byte with frame_eof SHALL be written, then the FSM SHALL go to CHECK.
REQ-022 CHECK: length = wptr; SHALL set rx_crc_rslt to 11 if length < MIN_LEN or overflow occurred, else 01 if residue = 0, else 10; rx_len = length (saturating at 2047); then go to DONE.
REQ-023 DONE: SHALL pulse rx_done for 1 cycle and return to IDLE; end-to-end, an eof byte accepted at cycle N gives rx_done high at N+2.
REQ-024 rx_crc_rslt and rx_len SHALL hold their values until the next rx_start, which clears rx_crc_rslt to 00.
REQ-025 Overflow: when wptr = 2047 and another non-eof byte arrives, SHALL set the overflow flag, stop writes (wptr holds), and keep consuming bytes until eof.
REQ-026 frame_sof during RECV SHALL abort the current frame (no rx_done), restart at address 0, and pulse rx_start again.
REQ-027 byte_valid with both sof and eof in IDLE SHALL store a 1-byte frame, then CHECK gives length error (11).
REQ-028 Bytes arriving in CHECK or DONE SHALL be dropped; an upstream gap of at least 2 cycles between frames is guaranteed.
REQ-029 The read port SHALL be independent of the write port (simple dual-port RAM) with 1-cycle registered read latency.
REQ-030 A read and a write to the same address in the same cycle SHALL return the old data.

Reset
REQ-031 reset SHALL force IDLE, wptr=0, CRC=0xFFFF, overflow=0, rx_start=0, rx_done=0, rx_crc_rslt=00, rx_len=0, rx_buf_rdata=0.
REQ-032 Buffer RAM contents SHALL NOT be cleared by reset.
REQ-033 reset mid-frame SHALL discard the frame with no rx_done, and SHALL win over any simultaneous byte_valid.

Verification
REQ-034 Frame 01 02 03 plus its correct CRC (5 bytes) -> rx_start 1 cycle after sof; rx_done at eof+2; rx_crc_rslt=01; rx_len=5; reads of addresses 0..4 return the bytes in order.
REQ-035 Same frame with the last byte bit-flipped -> rx_crc_rslt=10, rx_len=5.
REQ-036 4-byte frame -> rx_crc_rslt=11; a 2100-byte frame -> rx_crc_rslt=11, rx_len=2047, addresses 0..2046 hold bytes 0..2046.
REQ-037 sof, 10 bytes, new sof, then a valid 6-byte frame -> two rx_start pulses, one rx_done, rx_crc_rslt=01, rx_len=6.
REQ-038 reset asserted for 1 cycle mid-frame -> all outputs zero, no rx_done; the next valid frame completes with 01.
REQ-039 Read issued during RECV to an address being written -> old data returned with 1-cycle latency.

Source files
------------

// File: rtl/rx_frame_buf.sv
// Receive frame buffer: stores one deserialized frame into a dual-port RAM,
// checks its length and CRC-16 (0x1021) residue, and reports the result.
module rx_frame_buf #(
  parameter int BUF_AW  = 11,
  parameter int MIN_LEN = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              frame_sof,
  input  logic              frame_eof,
  input  logic              rx_buf_rden,
  input  logic [BUF_AW-1:0] rx_buf_raddr,
  output logic [7:0]        rx_buf_rdata,
  output logic              rx_start,
  output logic              rx_done,
  output logic [1:0]        rx_crc_rslt,
  output logic [BUF_AW-1:0] rx_len
);

  localparam int DEPTH = 1 << BUF_AW;
  localparam logic [BUF_AW:0] LAST = (BUF_AW+1)'(DEPTH - 1);
  localparam logic [BUF_AW:0] MINL = (BUF_AW+1)'(MIN_LEN);

  typedef enum logic [1:0] {IDLE, RECV, CHECK, DONE} state_e;

  state_e            state_q, state_d;
  logic [BUF_AW:0]   wptr_q, wptr_d;   // one extra bit so a full 2^AW-byte frame still counts
  logic [15:0]       crc_q, crc_d;
  logic              ovf_q, ovf_d;
  logic              start_q, start_d;
  logic [1:0]        rslt_q, rslt_d;
  logic [BUF_AW-1:0] len_q, len_d;
  logic [7:0]        rdata_q;
  logic              we, seed;
  logic [BUF_AW-1:0] waddr;
  logic [7:0]        mem [DEPTH];

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    crc_d   = crc_q;
    ovf_d   = ovf_q;
    start_d = 1'b0;
    rslt_d  = rslt_q;
    len_d   = len_q;
    we      = 1'b0;
    waddr   = '0;
    seed    = 1'b0;
    case (state_q)
      IDLE: if (byte_valid && frame_sof) seed = 1'b1;
      RECV: if (byte_valid) begin
        if (frame_sof) seed = 1'b1;
        else begin
          crc_d = crc_step(crc_q, byte_data);
          if (ovf_q || (wptr_q == LAST && !frame_eof)) ovf_d = 1'b1;
          else begin
            we     = 1'b1;
            waddr  = wptr_q[BUF_AW-1:0];
            wptr_d = wptr_q + 1'b1;
          end
          if (frame_eof) state_d = CHECK;
        end
      end
      CHECK: begin
        if (wptr_q < MINL || ovf_q) rslt_d = 2'b11;
        else if (crc_q == 16'h0)    rslt_d = 2'b01;
        else                        rslt_d = 2'b10;
        len_d   = (wptr_q > LAST) ? LAST[BUF_AW-1:0] : wptr_q[BUF_AW-1:0];
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A sof in IDLE or mid-frame always restarts the frame at address 0.
    if (seed) begin
      we      = 1'b1;
      waddr   = '0;
      wptr_d  = (BUF_AW+1)'(1);
      crc_d   = crc_step(16'hFFFF, byte_data);
      ovf_d   = 1'b0;
      start_d = 1'b1;
      rslt_d  = 2'b00;
      state_d = frame_eof ? CHECK : RECV;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      crc_q   <= 16'hFFFF;
      ovf_q   <= 1'b0;
      start_q <= 1'b0;
      rslt_q  <= 2'b00;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      crc_q   <= crc_d;
      ovf_q   <= ovf_d;
      start_q <= start_d;
      rslt_q  <= rslt_d;
      len_q   <= len_d;
    end
  end

  // RAM contents survive reset; only the gated write enable stops on reset.
  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= byte_data;
  end

  always_ff @(posedge clk) begin
    if (reset)            rdata_q <= '0;
    else if (rx_buf_rden) rdata_q <= mem[rx_buf_raddr];
  end

  assign rx_buf_rdata = rdata_q;
  assign rx_start     = start_q;
  assign rx_done      = (state_q == DONE);
  assign rx_crc_rslt  = rslt_q;
  assign rx_len       = len_q;

endmodule

// File: tb/tb_rx_frame_buf.sv
// Self-checking bench for rx_frame_buf: table vectors, random frames against a
// reference model, and hand-written abort / reset / read-during-write sequences.
module tb_rx_frame_buf;
  localparam int DEPTH = 2048;
  localparam int MINL  = 5;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    int         plen;     // payload bytes before CRC; -1 = single raw byte
    bit         fixed;    // payload 01 02 03 ...
    bit         corrupt;  // flip bit 0 of last byte
    logic [1:0] rslt;
    int         len;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, byte_valid, frame_sof, frame_eof, rx_buf_rden;
  logic [7:0]  byte_data;
  logic [10:0] rx_buf_raddr;
  logic [7:0]  rx_buf_rdata;
  logic        rx_start, rx_done;
  logic [1:0]  rx_crc_rslt;
  logic [10:0] rx_len;

  always #5 clk = ~clk;

  rx_frame_buf #(.BUF_AW(11), .MIN_LEN(MINL)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_sof(frame_sof), .frame_eof(frame_eof), .rx_buf_rden(rx_buf_rden),
    .rx_buf_raddr(rx_buf_raddr), .rx_buf_rdata(rx_buf_rdata), .rx_start(rx_start),
    .rx_done(rx_done), .rx_crc_rslt(rx_crc_rslt), .rx_len(rx_len)
  );

  int errors = 0, checks = 0;
  int edge_n = 0;
  int start_cnt = 0, done_cnt = 0, start_edge = -1, done_edge = -1;
  logic [1:0]  done_rslt;
  logic [10:0] done_len;
  int sof_edge, eof_edge, pos;
  logic [7:0] mem_m [DEPTH];
  bit         mem_v [DEPTH];

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (rx_start) begin
      start_cnt  <= start_cnt + 1;
      start_edge <= edge_n;
    end
    if (rx_done) begin
      done_cnt  <= done_cnt + 1;
      done_edge <= edge_n;
      done_rslt <= rx_crc_rslt;
      done_len  <= rx_len;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC of a byte stream as polynomial division over its bits, MSB first.
  function automatic logic [15:0] crc_of(input bq_t q);
    logic [15:0] r = 16'hFFFF;
    logic [7:0]  b;
    logic        fb;
    foreach (q[i]) begin
      b = q[i];
      for (int k = 7; k >= 0; k--) begin
        fb = r[15] ^ b[k];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h1021;
      end
    end
    return r;
  endfunction

  function automatic bq_t make_frame(input int plen, input bit fixed, input bit corrupt);
    bq_t q;
    logic [15:0] c;
    logic [7:0]  t;
    if (plen < 0) begin
      q.push_back(8'(($urandom)));
      return q;
    end
    for (int i = 0; i < plen; i++) q.push_back(fixed ? 8'(i + 1) : 8'($urandom));
    c = crc_of(q);
    q.push_back(c[15:8]);
    q.push_back(c[7:0]);
    if (corrupt) begin
      t = q[q.size()-1];
      t = t ^ 8'h01;
      q[q.size()-1] = t;
    end
    return q;
  endfunction

  task automatic idle(input int n);
    byte_valid = 1'b0; frame_sof = 1'b0; frame_eof = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives a frame; the model stores byte i at address i while it fits.
  // Optionally reads address rd_at while byte rd_at is written, and again next byte.
  task automatic send(input bq_t q, input bit do_eof, input bit gaps, input int rd_at);
    logic [7:0] exp_old;
    exp_old = 8'h00;
    for (int i = 0; i < q.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        byte_valid = 1'b0; frame_sof = 1'b0; frame_eof = 1'b0;
        @(posedge clk); #1;
      end
      byte_valid = 1'b1;
      byte_data  = q[i];
      frame_sof  = (i == 0);
      frame_eof  = do_eof && (i == q.size() - 1);
      rx_buf_rden = 1'b0;
      if (rd_at >= 0 && (i == rd_at || i == rd_at + 1)) begin
        rx_buf_rden  = 1'b1;
        rx_buf_raddr = 11'(rd_at);
        if (i == rd_at) exp_old = mem_m[rd_at];
      end
      @(posedge clk); #1;
      if (i == 0) begin sof_edge = edge_n; pos = 0; end
      if (frame_eof) eof_edge = edge_n;
      if (pos < DEPTH - 1 || (pos == DEPTH - 1 && frame_eof)) begin
        mem_m[pos] = q[i];
        mem_v[pos] = 1'b1;
      end
      pos++;
      if (rd_at >= 0 && i == rd_at)     chk("rdw_old_data", rx_buf_rdata, exp_old);
      if (rd_at >= 0 && i == rd_at + 1) chk("rdw_new_data", rx_buf_rdata, mem_m[rd_at]);
      rx_buf_rden = 1'b0;
    end
    byte_valid = 1'b0; frame_sof = 1'b0; frame_eof = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    for (int i = 0; i < 8 && done_cnt == prev; i++) begin
      @(posedge clk); #1;
    end
    chk("done_pulse", done_cnt, prev + 1);
  endtask

  task automatic readback(input int n, input string tag);
    for (int a = 0; a < n; a++) begin
      if (!mem_v[a]) continue;
      rx_buf_rden  = 1'b1;
      rx_buf_raddr = 11'(a);
      @(posedge clk); #1;
      chk(tag, rx_buf_rdata, mem_m[a]);
    end
    rx_buf_rden = 1'b0;
  endtask

  task automatic run_frame(input bq_t q, input logic [1:0] er, input int el,
                           input bit gaps, input int rd_at, input string tag);
    int s0, d0, n;
    s0 = start_cnt;
    d0 = done_cnt;
    send(q, 1'b1, gaps, rd_at);
    wait_done(d0);
    chk({tag, "_start_cnt"}, start_cnt, s0 + 1);
    chk({tag, "_start_lat"}, start_edge, sof_edge);
    chk({tag, "_done_lat"}, done_edge, eof_edge + 1);
    chk({tag, "_rslt"}, done_rslt, er);
    chk({tag, "_len"}, done_len, el);
    idle(2);
    chk({tag, "_rslt_hold"}, rx_crc_rslt, er);
    n = (q.size() < DEPTH - 1) ? q.size() : DEPTH - 1;
    readback(n, {tag, "_rd"});
  endtask

  vec_t tbl [9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t q, p;
    int L, s0, d0;
    logic [1:0] er;

    tbl[0] = '{3,    1'b1, 1'b0, 2'b01, 5};
    tbl[1] = '{3,    1'b1, 1'b1, 2'b10, 5};
    tbl[2] = '{2,    1'b0, 1'b0, 2'b11, 4};
    tbl[3] = '{-1,   1'b0, 1'b0, 2'b11, 1};
    tbl[4] = '{10,   1'b0, 1'b0, 2'b01, 12};
    tbl[5] = '{1,    1'b0, 1'b0, 2'b11, 3};
    tbl[6] = '{5,    1'b0, 1'b1, 2'b10, 7};
    tbl[7] = '{2098, 1'b0, 1'b0, 2'b11, 2047};
    tbl[8] = '{2045, 1'b0, 1'b0, 2'b01, 2047};

    reset = 1'b1; byte_valid = 1'b0; frame_sof = 1'b0; frame_eof = 1'b0;
    byte_data = 8'h00; rx_buf_rden = 1'b0; rx_buf_raddr = 11'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", rx_start, 0);
    chk("rst_done", rx_done, 0);
    chk("rst_rslt", rx_crc_rslt, 0);
    chk("rst_len", rx_len, 0);
    chk("rst_rdata", rx_buf_rdata, 0);
    reset = 1'b0;
    idle(2);

    // bytes without sof in IDLE are ignored
    s0 = start_cnt;
    byte_valid = 1'b1; byte_data = 8'h55; frame_eof = 1'b1;
    @(posedge clk); #1;
    idle(4);
    chk("nosof_ignored", start_cnt, s0);

    foreach (tbl[i])
      run_frame(make_frame(tbl[i].plen, tbl[i].fixed, tbl[i].corrupt),
                tbl[i].rslt, tbl[i].len, tbl[i].plen < 100, -1, $sformatf("tbl%0d", i));

    for (int r = 0; r < 25; r++) begin
      q  = make_frame($urandom_range(0, 40), 1'b0, 1'($urandom_range(0, 1)));
      L  = q.size();
      er = (L < MINL) ? 2'b11 : (crc_of(q) == 16'h0 ? 2'b01 : 2'b10);
      run_frame(q, er, L, 1'b1, -1, $sformatf("rnd%0d", r));
    end

    // abort: sof + 10 bytes, then a fresh valid 6-byte frame straight after
    s0 = start_cnt;
    d0 = done_cnt;
    p.delete();
    for (int i = 0; i < 11; i++) p.push_back(8'($urandom));
    send(p, 1'b0, 1'b0, -1);
    chk("abort_rslt_cleared", rx_crc_rslt, 0);
    q = make_frame(4, 1'b0, 1'b0);
    send(q, 1'b1, 1'b0, -1);
    wait_done(d0);
    chk("abort_rslt", done_rslt, 2'b01);
    chk("abort_len", done_len, 6);
    idle(4);
    chk("abort_start_cnt", start_cnt, s0 + 2);
    chk("abort_done_cnt", done_cnt, d0 + 1);
    readback(11, "abort_rd");

    // reset mid-frame, coinciding with a sof byte that must not be taken
    p.delete();
    for (int i = 0; i < 6; i++) p.push_back(8'($urandom));
    send(p, 1'b0, 1'b0, -1);
    d0 = done_cnt;
    byte_valid = 1'b1; frame_sof = 1'b1; byte_data = ~mem_m[0]; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; byte_valid = 1'b0; frame_sof = 1'b0;
    chk("midrst_start", rx_start, 0);
    chk("midrst_done", rx_done, 0);
    chk("midrst_rslt", rx_crc_rslt, 0);
    chk("midrst_len", rx_len, 0);
    chk("midrst_rdata", rx_buf_rdata, 0);
    idle(6);
    chk("midrst_no_done", done_cnt, d0);
    readback(1, "midrst_ram_kept");
    run_frame(make_frame(3, 1'b0, 1'b0), 2'b01, 5, 1'b0, -1, "postrst");

    // read of the address being written in the same cycle returns old data
    do q = make_frame(6, 1'b0, 1'b0); while (q[2] == mem_m[2]);
    run_frame(q, 2'b01, 8, 1'b0, 2, "rdw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
